note_event_recorder: RTL
========================

Name: note_event_recorder

Overview:
- Capture side of the piano datapath: the writer that produces the note records consumed by the playback/tone engine.
- Watches per-note key levels from the keyboard decoder, timestamps each press and release with a tick counter, and emits one record per completed note.
- Record format: {note_index[4:0], start_time[28:0], end_time[28:0]}, 63 bits, passed downstream over a valid/ready handshake (to note memory).

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- TICK_HZ, 1000, timestamp rate; divider terminal count = CLK_HZ/TICK_HZ-1.
- NUM_NOTES, 24, note lines. Index 0-13 white C4..B5, 14-23 black C#4..A#5.
- TS_W, 29, timestamp width.
- NOTE_W, 5, note index width.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rec_en  in  1  recording enable (level).
- rec_clear  in  1  synchronous clear pulse.
- note_keys  in  NUM_NOTES  key levels, 1 = held. Asynchronous to CLOCK_50.
- rec_ready  in  1  downstream accepts record.
- rec_valid  out  1  rec_data holds a valid record.
- rec_data  out  NUM_NOTES-agnostic 63 (NOTE_W+2*TS_W)  {note, start, end}.
- timestamp  out  TS_W  current time.
- drop_flag  out  1  sticky: a press was discarded.
- ts_sat  out  1  sticky: timestamp saturated.
- busy  out  1  any note active or pending, or rec_valid=1.

Behaviour:
- Reset (async): all outputs 0. Divider, timestamp, active[], pending[], start[], end[] and the output register cleared.
- Synchronizer: note_keys passes through a 2-FF synchronizer, then an edge-detect register. Edges act 3 cycles after the pin change.
- Tick divider:
  - Counts only while rec_en=1.
  - At terminal count it wraps to 0 and timestamp increments.
  - At 2^TS_W-1 the timestamp holds and ts_sat sets.
- rec_clear has highest priority. It clears the divider, timestamp, active, pending, drop_flag, ts_sat and rec_valid in the same cycle, even mid-handshake.
- Press: synced rising edge of note k while rec_en=1.
  - If active[k]=0 and pending[k]=0: active[k]<=1 and start[k]<=timestamp (value in the edge cycle).
  - If pending[k]=1: the press is discarded, drop_flag<=1, and the matching release is ignored.
- Release: synced falling edge while active[k]=1. active[k]<=0, pending[k]<=1, end[k]<=timestamp. end==start is legal (zero-length note).
- Simultaneous edges on several notes in one cycle: all are captured in that cycle.
- rec_en falling:
  - Every active note is force-released with end = current timestamp.
  - Edges while rec_en=0 are ignored.
  - A key already held when rec_en rises is not recorded until it is re-pressed.
- Output state machine, states EMPTY and FULL:
  - EMPTY: if any pending, select the lowest set index j, load rec_data <= {j, start[j], end[j]}, clear pending[j], go to FULL.
  - FULL: rec_valid=1 and rec_data is held stable while rec_ready=0.
  - On rec_valid & rec_ready: if another note is pending, load it in the same cycle and stay FULL; otherwise go to EMPTY.
  - Throughput: 1 record/cycle while rec_ready=1.
- Latency: release edge in cycle N sets pending in N+1, and rec_valid=1 with that record in N+2 (output empty).
- A note's pending bit is cleared only when its record loads, so a record is never overwritten before emission.

Test Plan:
- CLK_HZ=10, TICK_HZ=1, rec_en=1; press key 5 at ts=3, release at ts=7 -> single record {5,3,7}, accepted with rec_ready=1, busy returns to 0.
- Release keys 2 and 20 in the same cycle at ts=9, rec_ready=1 -> records {2,..,9} then {20,..,9} on consecutive cycles.
- rec_ready=0 for 20 cycles with a record valid -> rec_data stable, rec_valid held. Raising rec_ready gives exactly one transfer.
- Re-press key 5 while its record is still pending (rec_ready=0) -> drop_flag=1. After drain, only one record for key 5.
- Hold key 0 from ts=2, drop rec_en at ts=6 -> record {0,2,6}, timestamp frozen at 6. Then pulse rec_clear -> timestamp=0, drop_flag=0, rec_valid=0.
- Force timestamp to 2^29-2, run 2 ticks -> timestamp=2^29-1, ts_sat=1. Assert reset mid-FULL -> rec_valid=0 immediately.

Source files
------------

// File: rtl/note_event_recorder_if.sv
// Record handshake from the note event recorder to note memory.
// The recorder drives valid/data and holds both stable until ready is seen.
interface note_event_recorder_if #(
    parameter int REC_W = 63
);
    logic             rec_valid;
    logic             rec_ready;
    logic [REC_W-1:0] rec_data;

    modport master (output rec_valid, output rec_data, input rec_ready);
    modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/note_event_recorder.sv
// Timestamps key presses/releases and emits one {note, start, end} record per completed note.
//   state | meaning
//   EMPTY | output register free, loads the lowest pending note
//   FULL  | record presented, held until accepted
module note_event_recorder #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 1000,
    parameter int NUM_NOTES = 24,
    parameter int TS_W      = 29,
    parameter int NOTE_W    = 5
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  rec_en_i,
    input  logic                  rec_clear_i,
    input  logic [NUM_NOTES-1:0]  note_keys_i,
    output logic [TS_W-1:0]       timestamp_o,
    output logic                  drop_flag_o,
    output logic                  ts_sat_o,
    output logic                  busy_o,
    note_event_recorder_if.master rec_if
);

    localparam int DIV_TC = CLK_HZ / TICK_HZ - 1;
    localparam int DIV_W  = (DIV_TC > 0) ? $clog2(DIV_TC + 1) : 1;
    localparam int REC_W  = NOTE_W + 2 * TS_W;

    localparam logic [DIV_W-1:0] DIV_TC_V = DIV_W'(DIV_TC);
    localparam logic [TS_W-1:0]  TS_MAX   = '1;
    localparam logic [TS_W-1:0]  TS_PRE   = TS_MAX - TS_W'(1);

    typedef enum logic {EMPTY, FULL} state_t;

    logic [NUM_NOTES-1:0] key_s1_q, key_s2_q, key_d_q;
    logic [NUM_NOTES-1:0] rise, fall;
    logic [NUM_NOTES-1:0] active_q, active_d;
    logic [NUM_NOTES-1:0] pending_q, pending_d;
    logic [NUM_NOTES-1:0] start_we, end_we;
    logic [NUM_NOTES-1:0] sel_oh, pend_clr;
    logic [TS_W-1:0]      start_q [NUM_NOTES];
    logic [TS_W-1:0]      end_q   [NUM_NOTES];
    logic [DIV_W-1:0]     div_q;
    logic [TS_W-1:0]      ts_q;
    logic                 drop_q, drop_d;
    logic                 sat_q;
    logic [NOTE_W-1:0]    sel_idx;
    logic [REC_W-1:0]     sel_rec;
    logic                 take, load;
    state_t               state_q;
    logic                 rec_valid_q;
    logic [REC_W-1:0]     rec_data_q;

    assign rise = key_s2_q & ~key_d_q;
    assign fall = ~key_s2_q & key_d_q;

    // Lowest pending note wins the output register.
    assign sel_oh = pending_q & (~pending_q + NUM_NOTES'(1));

    always_comb begin
        sel_idx = '0;
        for (int k = NUM_NOTES - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                sel_idx = NOTE_W'(k);
            end
        end
    end

    assign sel_rec  = {sel_idx, start_q[sel_idx], end_q[sel_idx]};
    assign take     = (state_q == EMPTY) || (rec_valid_q && rec_if.rec_ready);
    assign load     = take && (|pending_q) && !rec_clear_i;
    assign pend_clr = load ? sel_oh : '0;

    always_comb begin
        active_d  = active_q;
        pending_d = pending_q & ~pend_clr;
        drop_d    = drop_q;
        start_we  = '0;
        end_we    = '0;
        for (int k = 0; k < NUM_NOTES; k++) begin
            if (!rec_en_i) begin
                // Recording stopped: close every open note at the frozen time.
                if (active_q[k]) begin
                    active_d[k]  = 1'b0;
                    pending_d[k] = 1'b1;
                    end_we[k]    = 1'b1;
                end
            end else if (rise[k]) begin
                if (pending_q[k]) begin
                    drop_d = 1'b1;
                end else if (!active_q[k]) begin
                    active_d[k] = 1'b1;
                    start_we[k] = 1'b1;
                end
            end else if (fall[k] && active_q[k]) begin
                active_d[k]  = 1'b0;
                pending_d[k] = 1'b1;
                end_we[k]    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_s1_q  <= '0;
            key_s2_q  <= '0;
            key_d_q   <= '0;
            div_q     <= '0;
            ts_q      <= '0;
            active_q  <= '0;
            pending_q <= '0;
            drop_q    <= 1'b0;
            sat_q     <= 1'b0;
            for (int k = 0; k < NUM_NOTES; k++) begin
                start_q[k] <= '0;
                end_q[k]   <= '0;
            end
        end else begin
            key_s1_q <= note_keys_i;
            key_s2_q <= key_s1_q;
            key_d_q  <= key_s2_q;
            if (rec_clear_i) begin
                div_q     <= '0;
                ts_q      <= '0;
                active_q  <= '0;
                pending_q <= '0;
                drop_q    <= 1'b0;
                sat_q     <= 1'b0;
            end else begin
                if (rec_en_i) begin
                    if (div_q == DIV_TC_V) begin
                        div_q <= '0;
                        if (ts_q != TS_MAX) begin
                            ts_q <= ts_q + TS_W'(1);
                        end
                        if (ts_q >= TS_PRE) begin
                            sat_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                active_q  <= active_d;
                pending_q <= pending_d;
                drop_q    <= drop_d;
                for (int k = 0; k < NUM_NOTES; k++) begin
                    if (start_we[k]) begin
                        start_q[k] <= ts_q;
                    end
                    if (end_we[k]) begin
                        end_q[k] <= ts_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            rec_valid_q <= 1'b0;
            rec_data_q  <= '0;
        end else if (rec_clear_i) begin
            state_q     <= EMPTY;
            rec_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load) begin
                        state_q     <= FULL;
                        rec_valid_q <= 1'b1;
                        rec_data_q  <= sel_rec;
                    end
                end
                FULL: begin
                    if (rec_if.rec_ready) begin
                        if (load) begin
                            rec_data_q <= sel_rec;
                        end else begin
                            state_q     <= EMPTY;
                            rec_valid_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign rec_if.rec_valid = rec_valid_q;
    assign rec_if.rec_data  = rec_data_q;
    assign timestamp_o      = ts_q;
    assign drop_flag_o      = drop_q;
    assign ts_sat_o         = sat_q;
    assign busy_o           = (|active_q) || (|pending_q) || rec_valid_q;

endmodule
